// File: rtl/softmax_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : softmax_seq_ctrl
//  Description : Serial-to-vector sequencer for the N-wide Q4.12 softmax
//                core. It collects N elements over a valid/ready handshake
//                and tracks their running signed maximum. It then pulses
//                the core clear and enables the core for LAT cycles. It
//                captures the probability vector and streams it back out
//                serially.
//                Optional feature macro: SOFTMAX_CTRL_PERF_EN adds the
//                perf_vec_cnt and perf_stall_cnt counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module softmax_seq_ctrl #(
    parameter int N   = 4,
    parameter int LAT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_data,
    output logic [N*16-1:0] core_x_flat,
    output logic [15:0]     core_max_x,
    output logic            core_rst,
    output logic            core_en,
    input  logic [N*16-1:0] core_prob_flat,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     out_data,
    output logic            out_last,
    output logic            busy
`ifdef SOFTMAX_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_vec_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    localparam int       IW        = $clog2(N);
    localparam int       CW        = (LAT > 1) ? $clog2(LAT) : 1;
    localparam bit [IW-1:0] C_LAST_IDX = IW'(N - 1);
    localparam bit [CW-1:0] C_RUN_INIT = CW'(LAT - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CLR   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wr_idx_q;
    logic [IW-1:0]   rd_idx_q;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     xbuf_q [N];
    logic [15:0]     pbuf_q [N];
    logic [15:0]     max_q;

    logic            w_accept;
    logic            w_out_hs;
    logic            w_run_done;

    assign w_accept   = in_valid & in_ready;
    assign w_out_hs   = out_valid & out_ready;
    assign w_run_done = (state_q == S_RUN) && (cnt_q == '0);

    // Expose the element buffer in the flat packing the core expects
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign core_x_flat[16*gi +: 16] = xbuf_q[gi];
    end
    assign core_max_x = max_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake/core control decode
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        core_rst  = 1'b0;
        core_en   = 1'b0;
        out_valid = 1'b0;
        out_data  = 16'h0000;
        out_last  = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && (wr_idx_q == C_LAST_IDX)) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                core_rst = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN: begin
                core_en = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                out_data  = pbuf_q[rd_idx_q];
                out_last  = (rd_idx_q == C_LAST_IDX);
                if (out_ready && (rd_idx_q == C_LAST_IDX)) begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Element buffer, running max, indices, latency counter and capture
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            cnt_q    <= '0;
            max_q    <= 16'h8000;
            for (int i = 0; i < N; i++) begin
                xbuf_q[i] <= 16'h0000;
                pbuf_q[i] <= 16'h0000;
            end
        end else begin
            if (w_accept) begin
                xbuf_q[wr_idx_q] <= in_data;
                // Slot 0 restarts the max; ties keep the earlier element
                if ((wr_idx_q == '0) || ($signed(in_data) > $signed(max_q))) begin
                    max_q <= in_data;
                end
                // The last slot holds its index until the drain finishes
                if (wr_idx_q != C_LAST_IDX) begin
                    wr_idx_q <= wr_idx_q + 1'b1;
                end
            end

            if (state_q == S_CLR) begin
                cnt_q <= C_RUN_INIT;
            end else if ((state_q == S_RUN) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (w_run_done) begin
                for (int i = 0; i < N; i++) begin
                    pbuf_q[i] <= core_prob_flat[16*i +: 16];
                end
            end

            if (w_out_hs) begin
                if (rd_idx_q == C_LAST_IDX) begin
                    rd_idx_q <= '0;
                    wr_idx_q <= '0;
                end else begin
                    rd_idx_q <= rd_idx_q + 1'b1;
                end
            end
        end
    end

`ifdef SOFTMAX_CTRL_PERF_EN
    logic [31:0] vec_cnt_q;
    logic [31:0] stall_cnt_q;

    // Completed-vector and output-stall counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt_q   <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (w_out_hs && out_last) begin
                vec_cnt_q <= vec_cnt_q + 32'd1;
            end
            if ((state_q == S_DRAIN) && !out_ready) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_vec_cnt   = vec_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_softmax_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_softmax_seq_ctrl
//  Description : Self-checking bench for softmax_seq_ctrl with a stand-in
//                softmax core whose output changes on every enable cycle.
//                Honours SOFTMAX_CTRL_PERF_EN for the perf counter ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_softmax_seq_ctrl;

    localparam int N   = 4;
    localparam int LAT = 8;

    typedef logic [15:0] vec_t [N];

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_data;
    logic [N*16-1:0] core_x_flat;
    logic [15:0]     core_max_x;
    logic            core_rst;
    logic            core_en;
    logic [N*16-1:0] core_prob_flat;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     out_data;
    logic            out_last;
    logic            busy;
`ifdef SOFTMAX_CTRL_PERF_EN
    logic [31:0]     perf_vec_cnt;
    logic [31:0]     perf_stall_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    int unsigned cur_seed = 0;
    int          en_cnt   = 0;

    always #5 clk = ~clk;

    softmax_seq_ctrl #(.N(N), .LAT(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .core_x_flat    (core_x_flat),
        .core_max_x     (core_max_x),
        .core_rst       (core_rst),
        .core_en        (core_en),
        .core_prob_flat (core_prob_flat),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy)
`ifdef SOFTMAX_CTRL_PERF_EN
        ,
        .perf_vec_cnt   (perf_vec_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Stand-in core output: a distinct pattern for every enable count
    function automatic logic [15:0] pv(input int unsigned s, input int k, input int i);
        return 16'((s >> (i * 4)) ^ (k * 32'h1357) ^ (i * 32'h2468));
    endfunction

    // Stand-in core enable counter, cleared by the clear pulse
    always @(posedge clk) begin
        if (core_rst)     en_cnt <= 0;
        else if (core_en) en_cnt <= en_cnt + 1;
    end

    // Stand-in core probability bus
    always_comb begin
        core_prob_flat = '0;
        for (int i = 0; i < N; i++) core_prob_flat[16*i +: 16] = pv(cur_seed, en_cnt, i);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference max: largest element as a signed integer
    function automatic logic [15:0] ref_max(input vec_t v);
        int m;
        m = int'($signed(v[0]));
        for (int i = 1; i < N; i++)
            if (int'($signed(v[i])) > m) m = int'($signed(v[i]));
        return 16'(m);
    endfunction

    function automatic logic [N*16-1:0] ref_pack(input vec_t v);
        logic [N*16-1:0] p;
        for (int i = 0; i < N; i++) p[16*i +: 16] = v[i];
        return p;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = 16'($urandom);
        return v;
    endfunction

    // Offer N elements; returns right after the edge that accepts the last
    task automatic load_vec(input vec_t v, input bit toggle, output int accepts);
        int idx = 0;
        int guard = 0;
        accepts = 0;
        cur_seed = $urandom;
        while (idx < N && guard < 64) begin
            in_valid = toggle ? ((guard % 2) == 0) : 1'b1;
            in_data  = v[idx];
            if (in_valid && in_ready) begin
                idx++;
                accepts++;
            end
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (guard >= 64) chk("load_timeout", 64'(idx), 64'(N));
    endtask

    // From CLR onward: core sequencing, latency, drain data and handshakes
    task automatic finish_vec(input vec_t v, input int stall_slot, input int stall_len,
                              input bit hold, input logic [15:0] hold_val);
        int cycles = 0;
        int en_cyc = 0;
        int rst_cyc = 0;
        bit ready_leak = 1'b0;
        logic [15:0] exp_p;
`ifdef SOFTMAX_CTRL_PERF_EN
        logic [31:0] st0 = perf_stall_cnt;
`endif
        if (hold) begin
            in_valid = 1'b1;
            in_data  = hold_val;
        end
        chk("clr_max",    64'(core_max_x), 64'(ref_max(v)));
        chk("clr_xflat",  64'(core_x_flat), 64'(ref_pack(v)));
        chk("clr_busy",   64'(busy), 64'd1);
        while (!out_valid && cycles < 100) begin
            if (core_en)  en_cyc++;
            if (core_rst) rst_cyc++;
            if (in_ready) ready_leak = 1'b1;
            tick();
            cycles++;
        end
        chk("first_out_latency", 64'(cycles), 64'(1 + LAT));
        chk("core_en_cycles",    64'(en_cyc), 64'(LAT));
        chk("core_rst_cycles",   64'(rst_cyc), 64'd1);
        chk("max_stable_run",    64'(core_max_x), 64'(ref_max(v)));
        for (int k = 0; k < N; k++) begin
            int s = 0;
            exp_p = pv(cur_seed, LAT - 1, k);
            forever begin
                out_ready = !((k == stall_slot) && (s < stall_len));
                if (in_ready) ready_leak = 1'b1;
                chk("out_valid", 64'(out_valid), 64'd1);
                chk("out_data",  64'(out_data), 64'(exp_p));
                chk("out_last",  64'(out_last), 64'(k == N - 1));
                tick();
                if (out_ready) break;
                s++;
            end
        end
        out_ready = 1'b1;
        chk("in_ready_low_busy", 64'(ready_leak), 64'd0);
        chk("post_drain_ready",  64'(in_ready), 64'd1);
        chk("post_drain_busy",   64'(busy), 64'd0);
        chk("post_drain_valid",  64'(out_valid), 64'd0);
`ifdef SOFTMAX_CTRL_PERF_EN
        chk("perf_stall_delta", 64'(perf_stall_cnt - st0), 64'(stall_len));
`endif
    endtask

    task automatic run_vec(input vec_t v, input bit toggle, input int stall_slot,
                           input int stall_len, input bit hold, input logic [15:0] hold_val);
        int acc;
        load_vec(v, toggle, acc);
        chk("accept_count", 64'(acc), 64'(N));
        finish_vec(v, stall_slot, stall_len, hold, hold_val);
    endtask

    initial begin
        vec_t v, v2;
        int acc;
`ifdef SOFTMAX_CTRL_PERF_EN
        logic [31:0] vc0;
`endif
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 16'h0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  64'(in_ready), 64'd1);
        chk("rst_core_rst",  64'(core_rst), 64'd0);
        chk("rst_core_en",   64'(core_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last",  64'(out_last), 64'd0);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_out_data",  64'(out_data), 64'd0);
        chk("rst_max",       64'(core_max_x), 64'h8000);
        chk("rst_xflat",     64'(core_x_flat), 64'd0);

        // Nominal vector
        v = '{16'hEC80, 16'hFE18, 16'h2771, 16'h15DB};
        chk("nominal_ref_max", 64'(ref_max(v)), 64'h2771);
        run_vec(v, 1'b0, -1, 0, 1'b0, 16'h0);

        // All-negative vector with a tie for the maximum
        v = '{16'h8000, 16'hFFFF, 16'hC000, 16'hFFFF};
        run_vec(v, 1'b0, -1, 0, 1'b0, 16'h0);

        // Toggling in_valid, then a next element held during CLR/RUN/DRAIN
        v  = rand_vec();
        v2 = rand_vec();
        run_vec(v, 1'b1, -1, 0, 1'b1, v2[0]);
        run_vec(v2, 1'b0, -1, 0, 1'b0, 16'h0);

        // Output backpressure on element 2
        v = rand_vec();
        run_vec(v, 1'b0, 2, 5, 1'b0, 16'h0);

        // Reset during RUN cycle 3
        v = rand_vec();
        load_vec(v, 1'b0, acc);
        tick();
        tick();
        tick();
        chk("mid_run_en", 64'(core_en), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        chk("mrst_core_en",  64'(core_en), 64'd0);
        chk("mrst_max",      64'(core_max_x), 64'h8000);
        chk("mrst_busy",     64'(busy), 64'd0);
        chk("mrst_xflat",    64'(core_x_flat), 64'd0);
        repeat (LAT + 2) begin
            tick();
            chk("mrst_idle_valid", 64'(out_valid | core_en), 64'd0);
        end
        v = rand_vec();
        run_vec(v, 1'b0, -1, 0, 1'b0, 16'h0);

        // Back-to-back vectors, then a few randomized ones
`ifdef SOFTMAX_CTRL_PERF_EN
        vc0 = perf_vec_cnt;
`endif
        v = '{16'h7FFF, 16'h0001, 16'h0002, 16'h0003};
        run_vec(v, 1'b0, -1, 0, 1'b0, 16'h0);
        v = '{16'h9000, 16'hA000, 16'h8001, 16'hB000};
        run_vec(v, 1'b0, -1, 0, 1'b0, 16'h0);
`ifdef SOFTMAX_CTRL_PERF_EN
        chk("perf_vec_delta", 64'(perf_vec_cnt - vc0), 64'd2);
`endif
        repeat (6) begin
            v = rand_vec();
            run_vec(v, $urandom_range(0, 1) == 1, $urandom_range(0, N - 1),
                    $urandom_range(0, 3), 1'b0, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
